// File: rtl/regfile_mp.sv
// regfile_mp: NREAD-read / 1-write integer register file for the decode stage.
// Registered reads with write-first bypass, hardwired zero register, async
// active-high reset. Optional pending-write scoreboard enabled by defining
// REGFILE_SCOREBOARD_EN (adds iss_en/iss_rd/rbusy and a busy vector).
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  output logic [NREAD-1:0]      rbusy,
`endif
  input  logic [NREAD-1:0]      re,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd
);

  logic [XLEN-1:0]       regs_q [NREG];
  logic [XLEN-1:0]       regs_d [NREG];
  logic [NREAD*XLEN-1:0] rd_q, rd_d;

  // Post-write register image; reading it gives write-first bypass and a
  // zero register for free.
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != '0)) begin
      regs_d[wa] = wd;
    end
    regs_d[0] = '0;
  end

  // Per-port read capture; disabled ports hold their last value.
  always_comb begin
    rd_d = rd_q;
    for (int i = 0; i < NREAD; i++) begin
      if (re[i]) begin
        rd_d[i*XLEN +: XLEN] = regs_d[ra[i*AW +: AW]];
      end
    end
  end

  // Register array and read data state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      rd_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd_q   <= rd_d;
    end
  end

  assign rd = rd_q;

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0]  busy_q, busy_d;
  logic [NREAD-1:0] rbusy_q, rbusy_d;

  // Pending-write tracking: writeback clears, issue sets; a same-cycle issue
  // to the same register wins because it is a newer pending write.
  always_comb begin
    busy_d = busy_q;
    if (we && (wa != '0)) begin
      busy_d[wa] = 1'b0;
    end
    if (iss_en && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy flag per read port, sampled from the post-edge busy state.
  always_comb begin
    rbusy_d = rbusy_q;
    for (int i = 0; i < NREAD; i++) begin
      if (re[i]) begin
        rbusy_d[i] = busy_d[ra[i*AW +: AW]];
      end
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      rbusy_q <= '0;
    end else begin
      busy_q  <= busy_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rbusy = rbusy_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios plus randomized traffic against an
// array-based reference model of the register file.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NREAD = 2;
  localparam int AW    = $clog2(NREG);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREAD-1:0]      re;
  logic [NREAD*AW-1:0]   ra;
  logic [NREAD*XLEN-1:0] rd;
  logic                  we;
  logic [AW-1:0]         wa;
  logic [XLEN-1:0]       wd;
`ifdef REGFILE_SCOREBOARD_EN
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic [NREAD-1:0]      rbusy;
`endif

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef REGFILE_SCOREBOARD_EN
    .iss_en(iss_en),
    .iss_rd(iss_rd),
    .rbusy (rbusy),
`endif
    .re    (re),
    .ra    (ra),
    .rd    (rd),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [XLEN-1:0] m_reg   [NREG];
  logic [XLEN-1:0] m_rd    [NREAD];
  bit              m_busy  [NREG];
  bit              m_rbusy [NREAD];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
    for (int i = 0; i < NREAD; i++) begin
      m_rd[i]    = '0;
      m_rbusy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    re = '0;
    ra = '0;
    we = 1'b0;
    wa = '0;
    wd = '0;
`ifdef REGFILE_SCOREBOARD_EN
    iss_en = 1'b0;
    iss_rd = '0;
`endif
  endtask

  task automatic rport(input int i, input int a);
    re[i] = 1'b1;
    ra[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int a, input logic [XLEN-1:0] d);
    we = 1'b1;
    wa = AW'(a);
    wd = d;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREAD; i++) begin
      chk($sformatf("%s_rd%0d", tag, i), 64'(rd[i*XLEN +: XLEN]), 64'(m_rd[i]));
`ifdef REGFILE_SCOREBOARD_EN
      chk($sformatf("%s_rbusy%0d", tag, i), 64'(rbusy[i]), 64'(m_rbusy[i]));
`endif
    end
  endtask

  // One clock: predict from current inputs, clock, compare 1 time unit later.
  task automatic cycle(input string tag);
    logic [XLEN-1:0] nrd [NREAD];
    int a;
    for (int i = 0; i < NREAD; i++) begin
      nrd[i] = m_rd[i];
      if (re[i]) begin
        a = int'(ra[i*AW +: AW]);
        if (a == 0)                          nrd[i] = '0;
        else if (we && int'(wa) == a)        nrd[i] = wd;
        else                                 nrd[i] = m_reg[a];
      end
    end
`ifdef REGFILE_SCOREBOARD_EN
    if (we && wa != 0) m_busy[wa] = 1'b0;
    if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    for (int i = 0; i < NREAD; i++)
      if (re[i]) m_rbusy[i] = m_busy[ra[i*AW +: AW]];
`endif
    if (we && wa != 0) m_reg[wa] = wd;
    for (int i = 0; i < NREAD; i++) m_rd[i] = nrd[i];
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    idle();
    rst = 1'b1;
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Write then read on both ports
    idle(); wr(5, 32'hDEADBEEF); cycle("t2w");
    idle(); rport(0, 5); rport(1, 5); cycle("t2r");
    chk("t2_rd0", 64'(rd[31:0]),  64'h0000_0000_DEAD_BEEF);
    chk("t2_rd1", 64'(rd[63:32]), 64'h0000_0000_DEAD_BEEF);

    // Same-cycle write/read bypass
    idle(); wr(7, 32'h1234); rport(0, 7); cycle("t3");
    chk("t3_bypass", 64'(rd[31:0]), 64'h1234);

    // Zero register
    idle(); wr(0, 32'hFFFFFFFF); cycle("t4w");
    idle(); rport(0, 0); rport(1, 0); cycle("t4r");
    chk("t4_zero", 64'(rd[31:0]), 64'h0);
    idle(); wr(0, 32'hFFFFFFFF); rport(0, 0); cycle("t4b");
    chk("t4_zero_bypass", 64'(rd[31:0]), 64'h0);

    // Hold with re=0
    idle(); wr(9, 32'hAA); cycle("t5w");
    idle(); rport(1, 9); cycle("t5r");
    chk("t5_rd1", 64'(rd[63:32]), 64'hAA);
    idle(); wr(9, 32'h55); ra[AW +: AW] = AW'(9); cycle("t5h1");
    chk("t5_hold1", 64'(rd[63:32]), 64'hAA);
    idle(); ra[AW +: AW] = AW'(9); cycle("t5h2");
    chk("t5_hold2", 64'(rd[63:32]), 64'hAA);
    idle(); rport(1, 9); cycle("t5r2");
    chk("t5_reread", 64'(rd[63:32]), 64'h55);

`ifdef REGFILE_SCOREBOARD_EN
    idle(); iss_en = 1'b1; iss_rd = 3; cycle("t6i");
    idle(); rport(0, 3); cycle("t6r");
    chk("t6_busy", 64'(rbusy[0]), 64'h1);
    idle(); wr(3, 32'h77); rport(0, 3); cycle("t6w");
    chk("t6_clear", 64'(rbusy[0]), 64'h0);
    chk("t6_clear_rd", 64'(rd[31:0]), 64'h77);
    idle(); wr(3, 32'h88); iss_en = 1'b1; iss_rd = 3; rport(0, 3); cycle("t6s");
    chk("t6_setwins", 64'(rbusy[0]), 64'h1);
    chk("t6_setwins_rd", 64'(rd[31:0]), 64'h88);
`endif

    // Randomized traffic with a mid-run async reset
    for (int n = 0; n < 400; n++) begin
      idle();
      re = NREAD'($urandom);
      for (int i = 0; i < NREAD; i++)
        ra[i*AW +: AW] = AW'($urandom_range(0, 7));
      we = 1'($urandom);
      wa = AW'($urandom_range(0, 7));
      wd = $urandom;
`ifdef REGFILE_SCOREBOARD_EN
      iss_en = 1'($urandom);
      iss_rd = AW'($urandom_range(0, 7));
`endif
      cycle("rnd");

      if (n == 200) begin
        idle(); wr(4, 32'h123); rport(0, 4);
        rst = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
        for (int a = 1; a < NREG; a++) begin
          idle(); rport(0, a); rport(1, NREG - a); cycle("post_rst");
          chk("post_rst_zero", 64'(rd[31:0]), 64'h0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
